// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - four-requester memory port arbiter, round-robin or fixed priority, with grant watchdog
module mem_port_arbiter #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] req,
  input  logic       fixed_prio,
  input  logic       mem_resp,
  output logic [1:0] sel,
  output logic [3:0] gnt,
  output logic       mem_req,
  output logic [3:0] ack,
  output logic       timeout_err
);

  localparam int CW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

  typedef enum logic {IDLE, BUSY} state_t;

  state_t          state_q, state_d;
  logic [1:0]      sel_q, sel_d;
  logic [1:0]      last_q, last_d;
  logic [3:0]      gnt_q, gnt_d;
  logic            mem_req_q, mem_req_d;
  logic            timeout_err_q, timeout_err_d;
  logic [CW-1:0]   cnt_q, cnt_d;

  logic [3:0]      arb_cand;
  logic [1:0]      cand_idx;
  logic [1:0]      arb_idx;
  logic            arb_found;
  logic            expire;
  logic            do_grant;

  // The current grantee is masked out while busy: its req only drops the cycle after ack.
  always_comb begin
    arb_cand  = (state_q == IDLE) ? req : (req & ~gnt_q);
    arb_found = 1'b0;
    arb_idx   = 2'd0;
    cand_idx  = 2'd0;
    for (int k = 0; k < 4; k++) begin
      cand_idx = fixed_prio ? 2'(k) : (last_q + 2'(k) + 2'd1);
      if (!arb_found && arb_cand[cand_idx]) begin
        arb_found = 1'b1;
        arb_idx   = cand_idx;
      end
    end
  end

  assign expire = (TIMEOUT_CYCLES != 0) && (cnt_q == CW'(TIMEOUT_CYCLES - 1));

  always_comb begin
    state_d       = state_q;
    sel_d         = sel_q;
    last_d        = last_q;
    gnt_d         = gnt_q;
    mem_req_d     = mem_req_q;
    cnt_d         = cnt_q;
    timeout_err_d = 1'b0;
    do_grant      = 1'b0;
    case (state_q)
      IDLE: do_grant = arb_found;
      BUSY: begin
        if (mem_resp || expire) begin
          timeout_err_d = ~mem_resp;
          if (arb_found) begin
            do_grant = 1'b1;
          end else begin
            state_d   = IDLE;
            gnt_d     = 4'b0000;
            mem_req_d = 1'b0;
            cnt_d     = '0;
          end
        end else if (cnt_q != {CW{1'b1}}) begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
    if (do_grant) begin
      state_d   = BUSY;
      sel_d     = arb_idx;
      gnt_d     = 4'b0001 << arb_idx;
      mem_req_d = 1'b1;
      last_d    = arb_idx;
      cnt_d     = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      sel_q         <= 2'd0;
      last_q        <= 2'd3;
      gnt_q         <= 4'b0000;
      mem_req_q     <= 1'b0;
      timeout_err_q <= 1'b0;
      cnt_q         <= '0;
    end else begin
      state_q       <= state_d;
      sel_q         <= sel_d;
      last_q        <= last_d;
      gnt_q         <= gnt_d;
      mem_req_q     <= mem_req_d;
      timeout_err_q <= timeout_err_d;
      cnt_q         <= cnt_d;
    end
  end

  assign sel         = sel_q;
  assign gnt         = gnt_q;
  assign mem_req     = mem_req_q;
  assign timeout_err = timeout_err_q;
  assign ack         = gnt_q & {4{mem_resp & mem_req_q}};

endmodule
